// File: rtl/tcdm2axi_bridge.sv
// TCDM-target to AXI4-master bridge: one single-beat AXI4 transaction per 32-bit TCDM
// request, a single transaction in flight, response returned on the TCDM r-channel.

package tcdm2axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 6;
  localparam int unsigned USER_W = 6;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [USER_W-1:0] user;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

endpackage

module tcdm2axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID         = 0,
  parameter type         axi_req_t      = tcdm2axi_bridge_pkg::axi_req_t,
  parameter type         axi_resp_t     = tcdm2axi_bridge_pkg::axi_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tcdm_req_i,
  output logic        tcdm_gnt_o,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [31:0] tcdm_data_i,
  input  logic [3:0]  tcdm_be_i,
  output logic        tcdm_r_valid_o,
  output logic [31:0] tcdm_r_data_o,
  output logic        tcdm_r_opc_o,
  input  logic        tcdm_r_ready_i,
  output axi_req_t    axi_master_req_o,
  input  axi_resp_t   axi_master_resp_i,
  output logic        busy_o
);

  localparam int unsigned NUM_LANES  = AXI_DATA_WIDTH / 32;
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    B_WAIT,
    READ,
    R_WAIT,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          add_q, data_q;
  logic [3:0]           be_q;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_opc_q, rsp_opc_d;
  logic                 gnt;
  logic [LANE_BITS-1:0] lane;
  logic [STRB_WIDTH-1:0] lane_strb;
  logic [31:0]          lane_rdata;

  assign gnt = tcdm_req_i && (state_q == IDLE);

  if (NUM_LANES > 1) begin : g_lane
    assign lane = add_q[LANE_BITS+1:2];
  end else begin : g_single_lane
    assign lane = '0;
  end

  assign lane_strb  = STRB_WIDTH'(be_q) << {lane, 2'b00};
  assign lane_rdata = 32'(axi_master_resp_i.r.data >> {lane, 5'd0});

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rsp_data_d = rsp_data_q;
    rsp_opc_d  = rsp_opc_q;

    case (state_q)
      IDLE: begin
        if (tcdm_req_i) begin
          state_d   = tcdm_wen_i ? READ : WRITE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRITE: begin
        // AW and W finish independently; either order or the same cycle is fine.
        aw_done_d = aw_done_q | axi_master_resp_i.aw_ready;
        w_done_d  = w_done_q | axi_master_resp_i.w_ready;
        if (aw_done_d && w_done_d) state_d = B_WAIT;
      end
      B_WAIT: begin
        if (axi_master_resp_i.b_valid) begin
          rsp_data_d = '0;
          rsp_opc_d  = axi_master_resp_i.b.resp[1];
          state_d    = RESP;
        end
      end
      READ: begin
        if (axi_master_resp_i.ar_ready) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (axi_master_resp_i.r_valid) begin
          rsp_data_d = lane_rdata;
          rsp_opc_d  = axi_master_resp_i.r.resp[1];
          state_d    = RESP;
        end
      end
      RESP: begin
        if (tcdm_r_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_opc_q  <= 1'b0;
      add_q      <= '0;
      data_q     <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rsp_data_q <= rsp_data_d;
      rsp_opc_q  <= rsp_opc_d;
      if (gnt) begin
        add_q  <= tcdm_add_i;
        data_q <= tcdm_data_i;
        be_q   <= tcdm_be_i;
      end
    end
  end

  // Valids/readies decode straight from the state register, so reset drops them at once.
  always_comb begin
    axi_master_req_o = '0;

    axi_master_req_o.aw.id    = AXI_ID_WIDTH'(AXI_ID);
    axi_master_req_o.aw.addr  = AXI_ADDR_WIDTH'({add_q[31:2], 2'b00});
    axi_master_req_o.aw.len   = 8'd0;
    axi_master_req_o.aw.size  = 3'b010;
    axi_master_req_o.aw.burst = 2'b01;
    axi_master_req_o.aw.user  = {AXI_USER_WIDTH{1'b0}};

    axi_master_req_o.ar.id    = AXI_ID_WIDTH'(AXI_ID);
    axi_master_req_o.ar.addr  = AXI_ADDR_WIDTH'({add_q[31:2], 2'b00});
    axi_master_req_o.ar.len   = 8'd0;
    axi_master_req_o.ar.size  = 3'b010;
    axi_master_req_o.ar.burst = 2'b01;
    axi_master_req_o.ar.user  = {AXI_USER_WIDTH{1'b0}};

    axi_master_req_o.w.data = {NUM_LANES{data_q}};
    axi_master_req_o.w.strb = lane_strb;
    axi_master_req_o.w.last = 1'b1;
    axi_master_req_o.w.user = {AXI_USER_WIDTH{1'b0}};

    axi_master_req_o.aw_valid = (state_q == WRITE) && !aw_done_q;
    axi_master_req_o.w_valid  = (state_q == WRITE) && !w_done_q;
    axi_master_req_o.b_ready  = (state_q == B_WAIT);
    axi_master_req_o.ar_valid = (state_q == READ);
    axi_master_req_o.r_ready  = (state_q == R_WAIT);
  end

  logic unused_resp;
  assign unused_resp = ^{axi_master_resp_i.b.id, axi_master_resp_i.b.user,
                         axi_master_resp_i.b.resp[0], axi_master_resp_i.r.id,
                         axi_master_resp_i.r.last, axi_master_resp_i.r.user,
                         axi_master_resp_i.r.resp[0]};

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = (state_q == RESP);
  assign tcdm_r_data_o  = rsp_data_q;
  assign tcdm_r_opc_o   = rsp_opc_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Directed self-checking bench for tcdm2axi_bridge: inputs driven 1 time unit after
// the rising edge, outputs sampled on the falling edge.

module tb_tcdm2axi_bridge;
  import tcdm2axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, tcdm_r_opc, tcdm_r_ready, busy;
  logic [31:0] tcdm_add, tcdm_data, tcdm_r_data;
  logic [3:0]  tcdm_be;
  axi_req_t    axi_req;
  axi_resp_t   axi_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tcdm2axi_bridge dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .tcdm_req_i       (tcdm_req),
    .tcdm_gnt_o       (tcdm_gnt),
    .tcdm_add_i       (tcdm_add),
    .tcdm_wen_i       (tcdm_wen),
    .tcdm_data_i      (tcdm_data),
    .tcdm_be_i        (tcdm_be),
    .tcdm_r_valid_o   (tcdm_r_valid),
    .tcdm_r_data_o    (tcdm_r_data),
    .tcdm_r_opc_o     (tcdm_r_opc),
    .tcdm_r_ready_i   (tcdm_r_ready),
    .axi_master_req_o (axi_req),
    .axi_master_resp_i(axi_resp),
    .busy_o           (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_post();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_aw_valid"}, axi_req.aw_valid, 0);
    check({tag, "_w_valid"},  axi_req.w_valid, 0);
    check({tag, "_ar_valid"}, axi_req.ar_valid, 0);
    check({tag, "_b_ready"},  axi_req.b_ready, 0);
    check({tag, "_r_ready"},  axi_req.r_ready, 0);
    check({tag, "_r_valid"},  tcdm_r_valid, 0);
    check({tag, "_busy"},     busy, 0);
  endtask

  // Read with an immediately responding slave: gnt c0, AR c1, R c2, response c3.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] rdata,
                         input logic [1:0] rresp, input logic [31:0] exp_data);
    tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = addr; tcdm_r_ready = 1'b1;
    axi_resp.ar_ready = 1'b1; axi_resp.r_valid = 1'b1;
    axi_resp.r.data = rdata; axi_resp.r.resp = rresp; axi_resp.r.last = 1'b1;
    to_neg();
    check({tag, "_gnt"}, tcdm_gnt, 1);
    to_post();
    tcdm_req = 1'b0;
    to_neg();
    check({tag, "_ar_valid"}, axi_req.ar_valid, 1);
    check({tag, "_ar_addr"},  axi_req.ar.addr, {addr[31:2], 2'b00});
    check({tag, "_ar_len"},   axi_req.ar.len, 0);
    check({tag, "_ar_size"},  axi_req.ar.size, 2);
    check({tag, "_r_ready_early"}, axi_req.r_ready, 0);
    to_post();
    to_neg();
    check({tag, "_r_ready"}, axi_req.r_ready, 1);
    check({tag, "_ar_drop"}, axi_req.ar_valid, 0);
    to_post();
    to_neg();
    check({tag, "_rsp_valid"}, tcdm_r_valid, 1);
    check({tag, "_rsp_data"},  tcdm_r_data, exp_data);
    check({tag, "_rsp_opc"},   tcdm_r_opc, rresp[1]);
    to_post();
    to_neg();
    check({tag, "_done"}, busy, 0);
    to_post();
    axi_resp.r_valid = 1'b0;
  endtask

  initial begin
    int gnt_count;

    rst = 1'b1;
    tcdm_req = 1'b0; tcdm_wen = 1'b0; tcdm_r_ready = 1'b0;
    tcdm_add = '0; tcdm_data = '0; tcdm_be = '0;
    axi_resp = '0;

    #2;
    check_all_idle("rst");
    check("rst_r_data", tcdm_r_data, 0);
    check("rst_r_opc",  tcdm_r_opc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. Write, immediate slave, b OKAY.
    tcdm_req = 1'b1; tcdm_wen = 1'b0; tcdm_add = 32'h1000_0004;
    tcdm_data = 32'hDEAD_BEEF; tcdm_be = 4'b0011; tcdm_r_ready = 1'b1;
    axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
    axi_resp.b_valid = 1'b1; axi_resp.b.resp = 2'b00;
    to_neg();
    check("t1_gnt", tcdm_gnt, 1);
    check("t1_busy_c0", busy, 0);
    to_post();
    tcdm_req = 1'b0;
    to_neg();
    check("t1_aw_valid", axi_req.aw_valid, 1);
    check("t1_w_valid",  axi_req.w_valid, 1);
    check("t1_aw_addr",  axi_req.aw.addr, 32'h1000_0004);
    check("t1_w_strb",   axi_req.w.strb, 8'h30);
    check("t1_w_data",   axi_req.w.data, 64'hDEAD_BEEF_DEAD_BEEF);
    check("t1_w_last",   axi_req.w.last, 1);
    check("t1_aw_burst", axi_req.aw.burst, 2'b01);
    check("t1_b_ready_early", axi_req.b_ready, 0);
    to_post();
    to_neg();
    check("t1_b_ready", axi_req.b_ready, 1);
    check("t1_aw_drop", axi_req.aw_valid, 0);
    to_post();
    to_neg();
    check("t1_rsp_valid", tcdm_r_valid, 1);
    check("t1_rsp_opc",   tcdm_r_opc, 0);
    check("t1_rsp_data",  tcdm_r_data, 0);
    to_post();
    axi_resp.b_valid = 1'b0;
    to_neg();
    check("t1_done", busy, 0);
    to_post();

    // 2. Lane selection on reads.
    do_read("t2a", 32'h2000_0000, 64'h1111_1111_2222_2222, 2'b00, 32'h2222_2222);
    do_read("t2b", 32'h2000_0004, 64'h1111_1111_2222_2222, 2'b00, 32'h1111_1111);

    // 3. Write with aw_ready held off until c4, w_ready immediate.
    tcdm_req = 1'b1; tcdm_wen = 1'b0; tcdm_add = 32'h3000_0008;
    tcdm_data = 32'hCAFE_F00D; tcdm_be = 4'b1100;
    axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b1;
    axi_resp.b_valid = 1'b1; axi_resp.b.resp = 2'b00;
    to_neg();
    check("t3_gnt", tcdm_gnt, 1);
    to_post();
    tcdm_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) axi_resp.aw_ready = 1'b1;
      to_neg();
      check($sformatf("t3_aw_valid_c%0d", c), axi_req.aw_valid, 1);
      check($sformatf("t3_w_valid_c%0d", c),  axi_req.w_valid, (c == 1) ? 1 : 0);
      check($sformatf("t3_b_ready_c%0d", c),  axi_req.b_ready, 0);
      check($sformatf("t3_aw_addr_c%0d", c),  axi_req.aw.addr, 32'h3000_0008);
      check($sformatf("t3_w_strb_c%0d", c),   axi_req.w.strb, 8'h0C);
      check($sformatf("t3_w_data_c%0d", c),   axi_req.w.data, 64'hCAFE_F00D_CAFE_F00D);
      to_post();
    end
    axi_resp.aw_ready = 1'b0;
    to_neg();
    check("t3_aw_drop", axi_req.aw_valid, 0);
    check("t3_b_ready", axi_req.b_ready, 1);
    to_post();
    to_neg();
    check("t3_rsp_valid", tcdm_r_valid, 1);
    check("t3_rsp_opc",   tcdm_r_opc, 0);
    to_post();
    axi_resp.b_valid = 1'b0;
    to_neg();
    check("t3_done", busy, 0);
    to_post();

    // 4. SLVERR read, TCDM response back-pressured for two cycles, request held high.
    tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = 32'h4000_0000; tcdm_r_ready = 1'b0;
    axi_resp.ar_ready = 1'b1; axi_resp.r_valid = 1'b1;
    axi_resp.r.data = 64'hAAAA_BBBB_CCCC_DDDD; axi_resp.r.resp = 2'b10;
    to_neg();
    check("t4_gnt", tcdm_gnt, 1);
    to_post();
    to_neg();
    check("t4_gnt_c1", tcdm_gnt, 0);
    check("t4_ar_valid", axi_req.ar_valid, 1);
    to_post();
    to_neg();
    check("t4_gnt_c2", tcdm_gnt, 0);
    check("t4_r_ready", axi_req.r_ready, 1);
    to_post();
    for (int c = 3; c <= 5; c++) begin
      if (c == 5) tcdm_r_ready = 1'b1;
      to_neg();
      check($sformatf("t4_rsp_valid_c%0d", c), tcdm_r_valid, 1);
      check($sformatf("t4_rsp_opc_c%0d", c),   tcdm_r_opc, 1);
      check($sformatf("t4_rsp_data_c%0d", c),  tcdm_r_data, 32'hCCCC_DDDD);
      check($sformatf("t4_gnt_c%0d", c),       tcdm_gnt, 0);
      to_post();
    end
    tcdm_req = 1'b0;
    axi_resp.r_valid = 1'b0;
    to_neg();
    check("t4_done", busy, 0);
    to_post();

    // 5. Request held across three reads; stray b_valid must never be accepted.
    tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = 32'h2000_0004; tcdm_r_ready = 1'b1;
    axi_resp.ar_ready = 1'b1; axi_resp.r_valid = 1'b1; axi_resp.b_valid = 1'b1;
    axi_resp.r.data = 64'h5555_6666_7777_8888; axi_resp.r.resp = 2'b00;
    gnt_count = 0;
    for (int i = 0; i < 12; i++) begin
      to_neg();
      if (tcdm_gnt) gnt_count++;
      check($sformatf("t5_gnt_%0d", i),       tcdm_gnt, (i % 4 == 0) ? 1 : 0);
      check($sformatf("t5_ar_valid_%0d", i),  axi_req.ar_valid, (i % 4 == 1) ? 1 : 0);
      check($sformatf("t5_r_ready_%0d", i),   axi_req.r_ready, (i % 4 == 2) ? 1 : 0);
      check($sformatf("t5_rsp_valid_%0d", i), tcdm_r_valid, (i % 4 == 3) ? 1 : 0);
      check($sformatf("t5_b_ready_%0d", i),   axi_req.b_ready, 0);
      if (i % 4 == 3) check($sformatf("t5_rsp_data_%0d", i), tcdm_r_data, 32'h5555_6666);
      to_post();
    end
    tcdm_req = 1'b0;
    axi_resp.r_valid = 1'b0; axi_resp.b_valid = 1'b0;
    check("t5_gnt_total", gnt_count, 3);
    to_neg();
    check("t5_done", busy, 0);
    to_post();

    // 6. Asynchronous reset while waiting for R.
    tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = 32'h2000_0000;
    axi_resp.ar_ready = 1'b1; axi_resp.r_valid = 1'b0;
    to_neg();
    check("t6_gnt", tcdm_gnt, 1);
    to_post();
    tcdm_req = 1'b0;
    to_neg();
    check("t6_ar_valid", axi_req.ar_valid, 1);
    to_post();
    to_neg();
    check("t6_r_ready", axi_req.r_ready, 1);
    check("t6_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_idle("t6_async");
    check("t6_rsp_opc", tcdm_r_opc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_read("t6_post", 32'h2000_0000, 64'h1111_1111_2222_2222, 2'b00, 32'h2222_2222);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
